// File: rtl/vga_text_renderer_if.sv
// Text RAM / font ROM bus between the renderer and its two synchronous-read memories.
interface vga_text_renderer_if;
    logic [11:0] textAddr;
    logic [7:0]  textData;
    logic [10:0] fontAddr;
    logic [7:0]  fontData;

    modport master (
        output textAddr,
        output fontAddr,
        input  textData,
        input  fontData
    );

    modport slave (
        input  textAddr,
        input  fontAddr,
        output textData,
        output fontData
    );
endinterface

// File: rtl/vga_text_renderer.sv
// 80x30 character-cell pixel generator: three pixEn-gated stages from timing counters to serial video,
// with per-character inverse video and a blinking underline cursor.
module vga_text_renderer #(
    parameter int unsigned COLS      = 80,
    parameter int unsigned ROWS      = 30,
    parameter int unsigned BLINK_BIT = 4
) (
    input  logic                        CLK,
    input  logic                        nCLR,
    input  logic                        pixEn,
    input  logic [9:0]                  hCount,
    input  logic [9:0]                  vCount,
    input  logic                        bright,
    input  logic                        hSync,
    input  logic                        vSync,
    input  logic [6:0]                  cursorCol,
    input  logic [4:0]                  cursorRow,
    input  logic                        cursorEn,
    vga_text_renderer_if.master         mem,
    output logic                        VidOut,
    output logic                        hSyncOut,
    output logic                        vSyncOut,
    output logic                        brightOut
);
    localparam logic [6:0] COLS_W = 7'(COLS);
    localparam logic [4:0] ROWS_W = 5'(ROWS);

    logic [6:0]  col;
    logic [4:0]  row;
    logic [11:0] rowBase;
    logic [11:0] textIdx;
    logic        hit;
    logic        unusedVMsb;

    // stage 1
    logic [3:0]  glyphRow1;
    logic [2:0]  bitIdx1;
    logic        curHit1;
    logic        bright1;
    logic        hSync1;
    logic        vSync1;

    // stage 2 (glyph row lives in fontAddr[3:0])
    logic        inv2;
    logic [2:0]  bitIdx2;
    logic        curHit2;
    logic        bright2;
    logic        hSync2;
    logic        vSync2;

    logic        vSyncPrev;
    logic [7:0]  frameCnt;
    logic        curOn;
    logic        fontBit;
    logic        underline;
    logic        pix;

    assign unusedVMsb = vCount[9];

    always_comb begin
        col     = hCount[9:3];
        row     = vCount[8:4];
        // row*80 as row*64 + row*16
        rowBase = ({7'd0, row} << 6) + ({7'd0, row} << 4);
        textIdx = rowBase + {5'd0, col};
        hit     = cursorEn & (col == cursorCol) & (row == cursorRow)
                & (col < COLS_W) & (row < ROWS_W);
    end

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            mem.textAddr <= '0;
            glyphRow1    <= '0;
            bitIdx1      <= '0;
            curHit1      <= 1'b0;
            bright1      <= 1'b0;
            hSync1       <= 1'b0;
            vSync1       <= 1'b0;
        end else if (pixEn) begin
            mem.textAddr <= bright ? textIdx : '0;
            glyphRow1    <= vCount[3:0];
            bitIdx1      <= hCount[2:0];
            curHit1      <= hit;
            bright1      <= bright;
            hSync1       <= hSync;
            vSync1       <= vSync;
        end
    end

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            mem.fontAddr <= '0;
            inv2         <= 1'b0;
            bitIdx2      <= '0;
            curHit2      <= 1'b0;
            bright2      <= 1'b0;
            hSync2       <= 1'b0;
            vSync2       <= 1'b0;
        end else if (pixEn) begin
            mem.fontAddr <= {mem.textData[6:0], glyphRow1};
            inv2         <= mem.textData[7];
            bitIdx2      <= bitIdx1;
            curHit2      <= curHit1;
            bright2      <= bright1;
            hSync2       <= hSync1;
            vSync2       <= vSync1;
        end
    end

    // Blink timebase counts raw vSync rising edges every clock, independent of pixEn.
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            vSyncPrev <= 1'b0;
            frameCnt  <= '0;
        end else begin
            vSyncPrev <= vSync;
            if (vSync && !vSyncPrev) begin
                frameCnt <= frameCnt + 8'd1;
            end
        end
    end

    always_comb begin
        curOn     = frameCnt[BLINK_BIT];
        fontBit   = mem.fontData[3'd7 - bitIdx2];
        underline = curHit2 & curOn & (mem.fontAddr[3:0] >= 4'd14);
        pix       = fontBit ^ inv2 ^ underline;
    end

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            VidOut    <= 1'b0;
            hSyncOut  <= 1'b0;
            vSyncOut  <= 1'b0;
            brightOut <= 1'b0;
        end else if (pixEn) begin
            VidOut    <= pix & bright2;
            hSyncOut  <= hSync2;
            vSyncOut  <= vSync2;
            brightOut <= bright2;
        end
    end
endmodule
